cordic_host_regs: RTL and testbench
===================================

Name: cordic_host_regs

Overview:
- Memory-mapped host front-end that sits directly upstream of the CORDIC Controller.
- A simple request/response bus writes the operand registers (X, Y, Z) and the control word.
- On a start request it issues exactly one start cycle to the controller, then tracks the operation to completion or timeout.
- On completion it captures the controller's results and flags into read-only shadow registers, and raises a sticky host interrupt.

Parameters:
- p_WIDTH, 32, data width of operands, results and control word.
- p_START_BIT, 0, bit position of the start bit in the control word.
- p_READY_BIT, 0, bit position of the ready flag in the controller's status word.
- p_TIMEOUT, 255, maximum RUN cycles before the operation is abandoned.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  1  host request strobe.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  3  word address.
- req_wdata  in  p_WIDTH  write data.
- rsp_valid  out  1  read data valid.
- rsp_rdata  out  p_WIDTH  read data.
- req_err  out  1  one-cycle pulse on a rejected access.
- host_irq  out  1  sticky interrupt to host.
- x_input  out  p_WIDTH  to controller.
- y_input  out  p_WIDTH  to controller.
- z_input  out  p_WIDTH  to controller.
- ctrl_word  out  p_WIDTH  to controller.
- x_result  in  p_WIDTH  from controller.
- y_result  in  p_WIDTH  from controller.
- z_result  in  p_WIDTH  from controller.
- ctrl_status  in  p_WIDTH  controller status/flag word.
- cordic_irq  in  1  controller interrupt.

Behaviour:
- Reset:
  - One clock, clk. rst is synchronous, active-low: sampled only on the rising clk edge, and while low all state clears.
  - All outputs reset to 0. FSM resets to IDLE. All registers, shadows, flags and the timeout counter reset to 0.
- Register map (word address):
  - 0 = X, 1 = Y, 2 = Z, 3 = CTRL: read/write.
  - 4 = X_OUT, 5 = Y_OUT, 6 = Z_OUT: read-only.
  - 7 = STATUS: read-only. Bit0 done, bit1 timeout, bit2 busy. Bits[31:16] = captured ctrl_status[15:0].
- Reads:
  - rsp_valid and rsp_rdata are registered and appear 1 cycle after the req_valid cycle.
  - A read of STATUS clears done, timeout and host_irq in the same cycle the response is registered.
- Writes:
  - Take effect on the next edge.
  - A write to address 4-7 is ignored and pulses req_err for 1 cycle.
  - A write to 0-3 while busy (ARM or RUN) is ignored and pulses req_err.
- Outputs to controller:
  - x_input, y_input and z_input always equal the X, Y and Z registers.
  - ctrl_word equals CTRL with bit p_START_BIT forced to 0, except during ARM.
- FSM:
  - IDLE: a CTRL write with wdata[p_START_BIT]=1 stores the word (start bit stored as 0) and moves to ARM. done and timeout clear on this transition.
  - ARM: ctrl_word has p_START_BIT=1 for exactly this one cycle. Timeout counter loads 0. Next state RUN.
  - RUN: counter increments each cycle.
    - If cordic_irq=1 or ctrl_status[p_READY_BIT]=1: capture x/y/z_result into X_OUT/Y_OUT/Z_OUT, capture ctrl_status[15:0], set done, set host_irq. Next state IDLE.
    - Else if counter==p_TIMEOUT: set timeout, set host_irq, do not update shadows. Next state IDLE.
    - Completion takes priority over timeout in the same cycle.
  - busy = (state != IDLE).
- Boundary cases:
  - A CTRL write with start=0 in IDLE updates CTRL only; no FSM change.
  - A STATUS read in the same cycle that done is being set: the set wins. done stays 1 and host_irq stays 1; the returned value shows the pre-set state.
  - Back-to-back start requests: a second start is only legal in IDLE. A start arriving during ARM or RUN is rejected with req_err.
  - rst low mid-RUN: the FSM returns to IDLE, ctrl_word becomes 0, and no capture occurs.
- Latency: the start write lands at edge N. ARM is cycle N+1, and RUN begins at N+2.

Test Plan:
- Reset then read all 8 addresses -> every rsp_rdata = 0. rsp_valid arrives 1 cycle after each request. host_irq = 0.
- Write X=0x10000000, Y=0, Z=0xE0000000, then CTRL=0x0000F001 -> ctrl_word=0x0000F001 for exactly 1 cycle, then 0x0000F000. x_input=0x10000000. STATUS.busy=1.
- In RUN, drive x_result=0x11111111 and cordic_irq=1 at cycle 20 -> next cycle X_OUT=0x11111111, STATUS=done|captured flags, host_irq=1. A STATUS read returns done=1, and the following read returns done=0 with host_irq=0.
- Write X=0x5 during RUN -> req_err pulses 1 cycle and X is unchanged. A start write during RUN -> req_err, with no second ARM pulse.
- p_TIMEOUT=8, controller never ready -> after the 8th RUN cycle, STATUS.timeout=1, host_irq=1, X_OUT unchanged, FSM in IDLE.
- Assert rst=0 on the 3rd RUN cycle while ctrl_status ready=1 -> no capture, all outputs 0, and STATUS reads 0 after release.

Source files
------------

// File: rtl/cordic_host_regs_if.sv
// Host request/response bus between a bus master and the CORDIC host register block.
interface cordic_host_regs_if #(
  parameter int p_WIDTH = 32
) ();
  logic               req_valid;
  logic               req_we;
  logic [2:0]         req_addr;
  logic [p_WIDTH-1:0] req_wdata;
  logic               rsp_valid;
  logic [p_WIDTH-1:0] rsp_rdata;
  logic               req_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  rsp_valid, rsp_rdata, req_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output rsp_valid, rsp_rdata, req_err
  );
endinterface

// File: rtl/cordic_host_regs.sv
// Host register front-end for the CORDIC controller: operand/control registers,
// one-cycle start pulse, completion/timeout tracking and result shadow capture.
module cordic_host_regs #(
  parameter int p_WIDTH     = 32,
  parameter int p_START_BIT = 0,
  parameter int p_READY_BIT = 0,
  parameter int p_TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst,
  cordic_host_regs_if.slave  bus,
  output logic [p_WIDTH-1:0] x_input,
  output logic [p_WIDTH-1:0] y_input,
  output logic [p_WIDTH-1:0] z_input,
  output logic [p_WIDTH-1:0] ctrl_word,
  input  logic [p_WIDTH-1:0] x_result,
  input  logic [p_WIDTH-1:0] y_result,
  input  logic [p_WIDTH-1:0] z_result,
  input  logic [p_WIDTH-1:0] ctrl_status,
  input  logic               cordic_irq,
  output logic               host_irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ARM  = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  localparam int                 CW         = $clog2(p_TIMEOUT + 2);
  localparam logic [CW-1:0]      TIMEOUT_C  = CW'(p_TIMEOUT);
  localparam logic [CW-1:0]      CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [p_WIDTH-1:0] START_MASK = {{(p_WIDTH-1){1'b0}}, 1'b1} << p_START_BIT;

  state_t             state_r, state_nxt_s;
  logic [p_WIDTH-1:0] x_r, y_r, z_r, ctrl_r, ctrl_word_r, ctrl_nxt_s;
  logic [p_WIDTH-1:0] x_out_r, y_out_r, z_out_r;
  logic [15:0]        flags_r;
  logic               done_r, timeout_r, irq_r;
  logic [CW-1:0]      cnt_r, cnt_inc_s;
  logic               rsp_valid_r, err_r;
  logic [p_WIDTH-1:0] rsp_rdata_r, rdata_s, status_s;
  logic               wr_s, rd_s, busy_s, wr_ok_s, wr_err_s, start_s;
  logic               done_hit_s, to_hit_s, status_clr_s;
  logic               ctrl_status_unused_s;

  assign wr_s         = bus.req_valid & bus.req_we;
  assign rd_s         = bus.req_valid & ~bus.req_we;
  assign busy_s       = (state_r != ST_IDLE);
  assign wr_ok_s      = wr_s & ~bus.req_addr[2] & ~busy_s;
  assign wr_err_s     = wr_s & (bus.req_addr[2] | busy_s);
  assign start_s      = wr_ok_s & (bus.req_addr == 3'd3) & bus.req_wdata[p_START_BIT];
  assign cnt_inc_s    = cnt_r + CNT_ONE;
  // Completion beats timeout when both land on the same RUN cycle.
  assign done_hit_s   = (state_r == ST_RUN) & (cordic_irq | ctrl_status[p_READY_BIT]);
  assign to_hit_s     = (state_r == ST_RUN) & ~done_hit_s & (cnt_inc_s == TIMEOUT_C);
  assign status_clr_s = rd_s & (bus.req_addr == 3'd7);
  assign ctrl_status_unused_s = ^ctrl_status[p_WIDTH-1:16];

  // Next-state logic for the start/run tracking FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nxt_s = ST_ARM;
        else         state_nxt_s = ST_IDLE;
      end
      ST_ARM:  state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (done_hit_s || to_hit_s) state_nxt_s = ST_IDLE;
        else                        state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next CTRL value; the stored start bit is always cleared.
  always_comb begin
    ctrl_nxt_s = ctrl_r;
    if (wr_ok_s && (bus.req_addr == 3'd3)) ctrl_nxt_s = bus.req_wdata & ~START_MASK;
    else                                   ctrl_nxt_s = ctrl_r;
  end

  // Status word assembly and read-data mux.
  always_comb begin
    status_s                 = '0;
    status_s[0]              = done_r;
    status_s[1]              = timeout_r;
    status_s[2]              = busy_s;
    status_s[p_WIDTH-1 -: 16] = flags_r;
    case (bus.req_addr)
      3'd0:    rdata_s = x_r;
      3'd1:    rdata_s = y_r;
      3'd2:    rdata_s = z_r;
      3'd3:    rdata_s = ctrl_r;
      3'd4:    rdata_s = x_out_r;
      3'd5:    rdata_s = y_out_r;
      3'd6:    rdata_s = z_out_r;
      3'd7:    rdata_s = status_s;
      default: rdata_s = '0;
    endcase
  end

  // FSM state, host-writable registers and the controller-facing control word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      ctrl_r      <= '0;
      ctrl_word_r <= '0;
      cnt_r       <= '0;
    end else begin
      state_r     <= state_nxt_s;
      ctrl_r      <= ctrl_nxt_s;
      ctrl_word_r <= (state_nxt_s == ST_ARM) ? (ctrl_nxt_s | START_MASK) : ctrl_nxt_s;
      if (wr_ok_s) begin
        case (bus.req_addr)
          3'd0:    x_r <= bus.req_wdata;
          3'd1:    y_r <= bus.req_wdata;
          3'd2:    z_r <= bus.req_wdata;
          default: x_r <= x_r;
        endcase
      end
      if (state_r == ST_ARM)      cnt_r <= '0;
      else if (state_r == ST_RUN) cnt_r <= cnt_inc_s;
    end
  end

  // Result shadows, sticky flags, interrupt and bus response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_out_r     <= '0;
      y_out_r     <= '0;
      z_out_r     <= '0;
      flags_r     <= '0;
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
      irq_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      err_r       <= 1'b0;
    end else begin
      if (done_hit_s) begin
        x_out_r <= x_result;
        y_out_r <= y_result;
        z_out_r <= z_result;
        flags_r <= ctrl_status[15:0];
      end
      if (done_hit_s)                      done_r <= 1'b1;
      else if (start_s || status_clr_s)    done_r <= 1'b0;
      if (to_hit_s)                        timeout_r <= 1'b1;
      else if (start_s || status_clr_s)    timeout_r <= 1'b0;
      if (done_hit_s || to_hit_s)          irq_r <= 1'b1;
      else if (status_clr_s)               irq_r <= 1'b0;
      rsp_valid_r <= rd_s;
      if (rd_s) rsp_rdata_r <= rdata_s;
      err_r <= wr_err_s;
    end
  end

  assign x_input       = x_r;
  assign y_input       = y_r;
  assign z_input       = z_r;
  assign ctrl_word     = ctrl_word_r;
  assign host_irq      = irq_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.req_err   = err_r;

endmodule

// File: tb/tb_cordic_host_regs.sv
// Directed self-checking bench for cordic_host_regs (p_TIMEOUT = 8).
module tb_cordic_host_regs;

  logic        clk;
  logic        rst;
  logic [31:0] x_input, y_input, z_input, ctrl_word;
  logic [31:0] x_result, y_result, z_result, ctrl_status;
  logic        cordic_irq, host_irq;
  int          n_checks;
  int          n_errors;
  logic [31:0] rd_data;
  logic        rd_vld;
  logic        wr_err;

  cordic_host_regs_if #(.p_WIDTH(32)) bus ();

  cordic_host_regs #(
    .p_WIDTH(32), .p_START_BIT(0), .p_READY_BIT(0), .p_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .x_input(x_input), .y_input(y_input), .z_input(z_input), .ctrl_word(ctrl_word),
    .x_result(x_result), .y_result(y_result), .z_result(z_result),
    .ctrl_status(ctrl_status), .cordic_irq(cordic_irq), .host_irq(host_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, output logic err);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = a; bus.req_wdata = d;
    @(negedge clk);
    err = bus.req_err;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic vld);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a;
    @(negedge clk);
    d   = bus.rsp_rdata;
    vld = bus.rsp_valid;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 3'd0; bus.req_wdata = 32'h0;
    x_result = 32'h0; y_result = 32'h0; z_result = 32'h0; ctrl_status = 32'h0;
    cordic_irq = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_host_irq", {31'h0, host_irq}, 32'h0);
    check_eq("rst_ctrl_word", ctrl_word, 32'h0);
    check_eq("rst_x_input", x_input, 32'h0);
    check_eq("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check_eq("rst_req_err", {31'h0, bus.req_err}, 32'h0);
    rst = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd_data, rd_vld);
      check_eq($sformatf("rst_read_%0d", a), rd_data, 32'h0);
      check_eq($sformatf("rst_read_vld_%0d", a), {31'h0, rd_vld}, 32'h1);
    end
    @(negedge clk);
    check_eq("rsp_valid_one_cycle", {31'h0, bus.rsp_valid}, 32'h0);

    // Operand load and start
    bus_write(3'd0, 32'h1000_0000, wr_err);
    bus_write(3'd1, 32'h0000_0000, wr_err);
    bus_write(3'd2, 32'hE000_0000, wr_err);
    check_eq("x_input", x_input, 32'h1000_0000);
    check_eq("z_input", z_input, 32'hE000_0000);
    bus_write(3'd3, 32'h0000_F001, wr_err);
    check_eq("arm_ctrl_word", ctrl_word, 32'h0000_F001);
    @(negedge clk);
    check_eq("run_ctrl_word", ctrl_word, 32'h0000_F000);
    bus_read(3'd7, rd_data, rd_vld);
    check_eq("status_busy", rd_data, 32'h0000_0004);
    bus_write(3'd0, 32'h0000_0005, wr_err);
    check_eq("busy_write_err", {31'h0, wr_err}, 32'h1);
    bus_write(3'd3, 32'h0000_F001, wr_err);
    check_eq("busy_start_err", {31'h0, wr_err}, 32'h1);
    check_eq("no_second_arm", ctrl_word, 32'h0000_F000);
    check_eq("x_unchanged", x_input, 32'h1000_0000);

    // Completion via cordic_irq
    x_result = 32'h1111_1111; y_result = 32'h2222_2222; z_result = 32'h3333_3333;
    ctrl_status = 32'h0000_5A00; cordic_irq = 1'b1;
    @(negedge clk);
    cordic_irq = 1'b0;
    check_eq("done_host_irq", {31'h0, host_irq}, 32'h1);
    bus_read(3'd4, rd_data, rd_vld);
    check_eq("x_out", rd_data, 32'h1111_1111);
    bus_read(3'd6, rd_data, rd_vld);
    check_eq("z_out", rd_data, 32'h3333_3333);
    bus_read(3'd7, rd_data, rd_vld);
    check_eq("status_done", rd_data, 32'h5A00_0001);
    bus_read(3'd7, rd_data, rd_vld);
    check_eq("status_cleared", rd_data, 32'h5A00_0000);
    check_eq("irq_cleared", {31'h0, host_irq}, 32'h0);

    // Idle boundaries: read-only write and start=0 CTRL write
    bus_write(3'd5, 32'h1234_5678, wr_err);
    check_eq("ro_write_err", {31'h0, wr_err}, 32'h1);
    @(negedge clk);
    check_eq("req_err_one_cycle", {31'h0, bus.req_err}, 32'h0);
    bus_write(3'd3, 32'h0000_0300, wr_err);
    check_eq("ctrl_nostart_err", {31'h0, wr_err}, 32'h0);
    check_eq("ctrl_nostart_word", ctrl_word, 32'h0000_0300);
    bus_read(3'd7, rd_data, rd_vld);
    check_eq("ctrl_nostart_idle", rd_data, 32'h5A00_0000);

    // STATUS read colliding with done being set
    bus_write(3'd3, 32'h0000_0301, wr_err);
    check_eq("arm2_ctrl_word", ctrl_word, 32'h0000_0301);
    x_result = 32'h4444_4444; ctrl_status = 32'h0000_3C00;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 3'd7; cordic_irq = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0; cordic_irq = 1'b0;
    check_eq("collide_rdata", bus.rsp_rdata, 32'h5A00_0004);
    check_eq("collide_irq", {31'h0, host_irq}, 32'h1);
    bus_read(3'd7, rd_data, rd_vld);
    check_eq("collide_status", rd_data, 32'h3C00_0001);
    check_eq("collide_irq_clr", {31'h0, host_irq}, 32'h0);

    // Timeout: controller never ready
    x_result = 32'h9999_9999;
    bus_write(3'd3, 32'h0000_0301, wr_err);
    repeat (8) @(negedge clk);
    check_eq("pre_timeout_irq", {31'h0, host_irq}, 32'h0);
    @(negedge clk);
    check_eq("timeout_irq", {31'h0, host_irq}, 32'h1);
    bus_read(3'd7, rd_data, rd_vld);
    check_eq("timeout_status", rd_data, 32'h3C00_0002);
    bus_read(3'd4, rd_data, rd_vld);
    check_eq("timeout_x_out", rd_data, 32'h4444_4444);

    // Reset on the 3rd RUN cycle while ready is high
    bus_write(3'd3, 32'h0000_0301, wr_err);
    x_result = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    rst = 1'b0; ctrl_status = 32'h0000_0001;
    @(negedge clk);
    check_eq("midrun_rst_ctrl_word", ctrl_word, 32'h0);
    check_eq("midrun_rst_irq", {31'h0, host_irq}, 32'h0);
    check_eq("midrun_rst_x_input", x_input, 32'h0);
    rst = 1'b1; ctrl_status = 32'h0;
    bus_read(3'd7, rd_data, rd_vld);
    check_eq("midrun_rst_status", rd_data, 32'h0);
    bus_read(3'd4, rd_data, rd_vld);
    check_eq("midrun_rst_x_out", rd_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
